// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory request handshake,
// one-entry fetch buffer and the IF/ID pipeline register.
// Build option: define BRANCH_DELAY_SLOT_EN to keep the sequential successor
// of a taken branch (MIPS delay slot) instead of flushing it.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | first cycle after reset, no request issued
// REQ   | request at pc outstanding, words flow straight into IF/ID
// DRAIN | stale request (issued before a redirect) must still be accepted
// FULL  | word fetched while decode stalled, parked in the buffer
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic        req_state;
    logic        accept;
    logic        redir;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;

    // Request is held high in REQ and DRAIN; DRAIN presents the stale address.
    assign req_state      = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign imem_req       = req_state;
    assign imem_addr      = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign accept         = req_state & imem_ready;
    assign redir          = branch_taken & pc_write;
    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = {branch_target[31:2], 2'b00};

    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;

    // Next-state, PC, buffer and IF/ID update; fetch_stall flags a memory bubble.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        buf_instr_d   = buf_instr_q;
        buf_pc4_d     = buf_pc4_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        fetch_stall   = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_REQ;

            S_REQ: begin
                if (redir) begin
                    pc_d = target_aligned;
`ifdef BRANCH_DELAY_SLOT_EN
                    if (accept) begin
                        if_id_instr_d = imem_rdata;
                        if_id_pc4_d   = pc_plus4;
                        if_id_valid_d = 1'b1;
                    end else begin
                        if_id_instr_d = NOP_INSTR;
                        if_id_pc4_d   = 32'd0;
                        if_id_valid_d = 1'b0;
                        drain_addr_d  = pc_q;
                        state_d       = S_DRAIN;
                    end
`else
                    if_id_instr_d = NOP_INSTR;
                    if_id_pc4_d   = 32'd0;
                    if_id_valid_d = 1'b0;
                    if (!accept) begin
                        drain_addr_d = pc_q;
                        state_d      = S_DRAIN;
                    end
`endif
                end else if (accept) begin
                    pc_d = pc_plus4;
                    if (pc_write) begin
                        if_id_instr_d = imem_rdata;
                        if_id_pc4_d   = pc_plus4;
                        if_id_valid_d = 1'b1;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = pc_plus4;
                        state_d     = S_FULL;
                    end
                end else if (pc_write) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_pc4_d   = 32'd0;
                    if_id_valid_d = 1'b0;
                    fetch_stall   = 1'b1;
                end
            end

            S_DRAIN: begin
                if (redir) begin
                    pc_d = target_aligned;
                end
`ifdef BRANCH_DELAY_SLOT_EN
                // The drained word is the delay slot: deliver or park it.
                if (accept) begin
                    state_d = S_REQ;
                    if (pc_write) begin
                        if_id_instr_d = imem_rdata;
                        if_id_pc4_d   = drain_addr_q + 32'd4;
                        if_id_valid_d = 1'b1;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = drain_addr_q + 32'd4;
                        state_d     = S_FULL;
                    end
                end else if (pc_write) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_pc4_d   = 32'd0;
                    if_id_valid_d = 1'b0;
                end
`else
                if (pc_write) begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_pc4_d   = 32'd0;
                    if_id_valid_d = 1'b0;
                end
                if (accept) begin
                    state_d = S_REQ;
                end
`endif
            end

            S_FULL: begin
                if (pc_write) begin
                    state_d = S_REQ;
                    if (redir) begin
                        pc_d = target_aligned;
                    end
`ifdef BRANCH_DELAY_SLOT_EN
                    if_id_instr_d = buf_instr_q;
                    if_id_pc4_d   = buf_pc4_q;
                    if_id_valid_d = 1'b1;
`else
                    if (redir) begin
                        if_id_instr_d = NOP_INSTR;
                        if_id_pc4_d   = 32'd0;
                        if_id_valid_d = 1'b0;
                    end else begin
                        if_id_instr_d = buf_instr_q;
                        if_id_pc4_d   = buf_pc4_q;
                        if_id_valid_d = 1'b1;
                    end
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= {RESET_PC[31:2], 2'b00};
            drain_addr_q  <= 32'd0;
            buf_instr_q   <= NOP_INSTR;
            buf_pc4_q     <= 32'd0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc4_q     <= buf_pc4_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a stimulus process drives each cycle and
// queues the expected interface values from a reference model; a monitor pops
// and compares on the falling edge.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        pc_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_stall;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        stall;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } rec_t;

    rec_t sb[$];

    // reference model: program counter, pending stale fetch, parked words
    bit          m_started;
    logic [31:0] m_pc;
    bit          m_drain;
    logic [31:0] m_drain_addr;
    logic [31:0] m_buf_i[$];
    logic [31:0] m_buf_p[$];
    logic        m_v;
    logic [31:0] m_i;
    logic [31:0] m_p4;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc_write      (pc_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .fetch_stall   (fetch_stall)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started    = 1'b0;
        m_pc         = RESET_PC;
        m_drain      = 1'b0;
        m_drain_addr = 32'd0;
        m_buf_i.delete();
        m_buf_p.delete();
        m_v  = 1'b0;
        m_i  = NOP_INSTR;
        m_p4 = 32'd0;
    endtask

    task automatic set_ifid(input logic v, input logic [31:0] i, input logic [31:0] p);
        m_v  = v;
        m_i  = i;
        m_p4 = p;
    endtask

    // Drive one cycle of inputs and queue what the DUT must show during it.
    task automatic issue(input bit pw, input bit bt, input logic [31:0] tgt, input bit rdy);
        rec_t        r;
        bit          redir;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] ta;
        pc_write      = pw;
        branch_taken  = bt;
        branch_target = tgt;
        imem_ready    = rdy;
        redir   = bt && pw;
        ta      = tgt & 32'hFFFF_FFFC;
        r.valid = m_v;
        r.instr = m_i;
        r.pc4   = m_p4;
        r.req   = 1'b0;
        r.addr  = 32'd0;
        r.stall = 1'b0;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_buf_i.size() != 0) begin
            if (pw) begin
                if (redir) m_pc = ta;
`ifdef BRANCH_DELAY_SLOT_EN
                set_ifid(1'b1, m_buf_i[0], m_buf_p[0]);
`else
                if (redir) set_ifid(1'b0, NOP_INSTR, 32'd0);
                else       set_ifid(1'b1, m_buf_i[0], m_buf_p[0]);
`endif
                m_buf_i.delete();
                m_buf_p.delete();
            end
        end else begin
            r.req  = 1'b1;
            a      = m_drain ? m_drain_addr : m_pc;
            r.addr = a;
            w      = mem_word(a);
            if (m_drain) begin
`ifdef BRANCH_DELAY_SLOT_EN
                if (rdy) begin
                    if (pw) set_ifid(1'b1, w, a + 32'd4);
                    else begin
                        m_buf_i.push_back(w);
                        m_buf_p.push_back(a + 32'd4);
                    end
                    m_drain = 1'b0;
                end else if (pw) set_ifid(1'b0, NOP_INSTR, 32'd0);
`else
                if (pw) set_ifid(1'b0, NOP_INSTR, 32'd0);
                if (rdy) m_drain = 1'b0;
`endif
                if (redir) m_pc = ta;
            end else if (redir) begin
`ifdef BRANCH_DELAY_SLOT_EN
                if (rdy) set_ifid(1'b1, w, a + 32'd4);
                else begin
                    set_ifid(1'b0, NOP_INSTR, 32'd0);
                    m_drain      = 1'b1;
                    m_drain_addr = a;
                end
`else
                set_ifid(1'b0, NOP_INSTR, 32'd0);
                if (!rdy) begin
                    m_drain      = 1'b1;
                    m_drain_addr = a;
                end
`endif
                m_pc = ta;
            end else if (rdy) begin
                if (pw) set_ifid(1'b1, w, a + 32'd4);
                else begin
                    m_buf_i.push_back(w);
                    m_buf_p.push_back(a + 32'd4);
                end
                m_pc = a + 32'd4;
            end else if (pw) begin
                set_ifid(1'b0, NOP_INSTR, 32'd0);
                r.stall = 1'b1;
            end
        end
        sb.push_back(r);
    endtask

    task automatic cyc(input bit pw, input bit bt, input logic [31:0] tgt, input bit rdy);
        @(posedge clock);
        #1;
        issue(pw, bt, tgt, rdy);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_fetch_stall"}, {31'd0, fetch_stall}, 32'd0);
        chk({tag, "_if_id_valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_if_id_instr"}, if_id_instr, NOP_INSTR);
        chk({tag, "_if_id_pc4"}, if_id_pc4, 32'd0);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clock) begin
        rec_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
            if (e.req) chk("imem_addr", imem_addr, e.addr);
            chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, e.stall});
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("if_id_instr", if_id_instr, e.instr);
            chk("if_id_pc4", if_id_pc4, e.pc4);
        end
    end

    initial begin
        reset         = 1'b0;
        pc_write      = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        imem_ready    = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        issue(1'b1, 1'b0, 32'd0, 1'b1);

        // sequential fetch, memory wait, decode stall, redirects
        repeat (4) cyc(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b1, 32'h0000_0300, 1'b1);
        repeat (2) cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (4) cyc(1'b1, 1'b0, 32'd0, 1'b1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit          pw;
            bit          bt;
            bit          rdy;
            logic [31:0] tgt;
            pw  = ($urandom_range(0, 9) < 8);
            bt  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           tgt = 32'($urandom_range(0, 4095));
            cyc(pw, bt, tgt, rdy);
        end

        // reset asserted while a stale request is draining
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b1, 32'h0000_0400, 1'b0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("mid_drain_reset");
        @(posedge clock);
        #1;
        reset = 1'b1;
        issue(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (4) cyc(1'b1, 1'b0, 32'd0, 1'b1);

        @(posedge clock);
        #1;
        pc_write   = 1'b0;
        imem_ready = 1'b0;
        @(negedge clock);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
